ahb_resp_mux_n: RTL and testbench

Parametrised AHB-Lite slave-to-master response multiplexer for NUM_SLAVES slaves. It replaces the two-way RAM/ROM response mux. The data-phase select is registered internally from the address-phase decode, so the bus master sees the response of the slave it actually addressed. The block also contains a built-in default slave that returns a two-cycle ERROR for unmapped or multiply-decoded transfers, plus a saturating decode-error counter. It sits between the address decoder and the master's read-data/response inputs.

---
 rtl/ahb_resp_mux_n_if.sv | 28 ++
 rtl/ahb_resp_mux_n.sv | 113 +++++++++++
 tb/tb_ahb_resp_mux_n.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_resp_mux_n_if.sv
// Bus bundle between the address decoder, the slaves and the master-side
// response mux. The mux uses the slave modport; the master side drives the inputs.
interface ahb_resp_mux_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8
);
    logic [1:0]                   htrans;
    logic [NUM_SLAVES-1:0]        hsel_in;
    logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
    logic [NUM_SLAVES-1:0]        hreadyout_s;
    logic [NUM_SLAVES-1:0]        hresp_s;
    logic [DATA_W-1:0]            hr_data;
    logic                         hready;
    logic                         hresp;
    logic [NUM_SLAVES-1:0]        dsel;
    logic [CNT_W-1:0]             err_count;

    modport slave (
        input  htrans, hsel_in, hrdata_s, hreadyout_s, hresp_s,
        output hr_data, hready, hresp, dsel, err_count
    );

    modport master (
        output htrans, hsel_in, hrdata_s, hreadyout_s, hresp_s,
        input  hr_data, hready, hresp, dsel, err_count
    );
endinterface

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite N-way response mux with registered data-phase select, a built-in
// default slave issuing two-cycle ERRORs on bad decodes, and a saturating error counter.
module ahb_resp_mux_n #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_resp_mux_n_if.slave   bus
);
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam logic [1:0]       TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]       TRANS_SEQ    = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    ds_state_t             ds_state_q, ds_state_d;
    logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;

    logic                  addr_valid;
    logic                  hsel_onehot;
    logic                  hready_c;
    logic                  hresp_c;
    logic [DATA_W-1:0]     hr_data_c;
    logic [DATA_W-1:0]     slave_data;
    logic [DATA_W-1:0]     masked_data [NUM_SLAVES];

    assign addr_valid  = (bus.htrans == TRANS_NONSEQ) || (bus.htrans == TRANS_SEQ);
    assign hsel_onehot = (bus.hsel_in != '0) &&
                         ((bus.hsel_in & (bus.hsel_in - NUM_SLAVES'(1))) == '0);

    // dsel is one-hot or zero, so an AND-OR reduction acts as the data mux.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_mask
        assign masked_data[gi] = dsel_q[gi] ? bus.hrdata_s[gi*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        slave_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slave_data = slave_data | masked_data[i];
        end
    end

    always_comb begin
        hr_data_c = '0;
        hready_c  = 1'b1;
        hresp_c   = 1'b0;
        case (ds_state_q)
            DS_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = 1'b1;
            end
            DS_ERR2: begin
                hresp_c = 1'b1;
            end
            default: begin
                if (dsel_q != '0) begin
                    hr_data_c = slave_data;
                    hready_c  = |(dsel_q & bus.hreadyout_s);
                    hresp_c   = |(dsel_q & bus.hresp_s);
                end
            end
        endcase
    end

    // ERR1 always advances, even though hready is low, so the error is never cut short.
    always_comb begin
        ds_state_d  = ds_state_q;
        dsel_d      = dsel_q;
        err_count_d = err_count_q;
        if (ds_state_q == DS_ERR1) begin
            ds_state_d = DS_ERR2;
        end else if (hready_c) begin
            if (addr_valid && hsel_onehot) begin
                dsel_d     = bus.hsel_in;
                ds_state_d = DS_IDLE;
            end else if (addr_valid) begin
                dsel_d     = '0;
                ds_state_d = DS_ERR1;
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end else begin
                dsel_d     = '0;
                ds_state_d = DS_IDLE;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            ds_state_q  <= DS_IDLE;
            dsel_q      <= '0;
            err_count_q <= '0;
        end else begin
            ds_state_q  <= ds_state_d;
            dsel_q      <= dsel_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.hr_data   = hr_data_c;
    assign bus.hready    = hready_c;
    assign bus.hresp     = hresp_c;
    assign bus.dsel      = dsel_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n: a wide-counter and a 2-bit-counter instance
// share one stimulus stream; expectations go through a scoreboard queue.
module tb_ahb_resp_mux_n;
    localparam int NS = 4;
    localparam int DW = 32;

    logic clk;
    logic rst;

    ahb_resp_mux_n_if #(.NUM_SLAVES(NS), .DATA_W(DW), .CNT_W(8)) bus_a ();
    ahb_resp_mux_n_if #(.NUM_SLAVES(NS), .DATA_W(DW), .CNT_W(2)) bus_b ();

    assign bus_b.htrans      = bus_a.htrans;
    assign bus_b.hsel_in     = bus_a.hsel_in;
    assign bus_b.hrdata_s    = bus_a.hrdata_s;
    assign bus_b.hreadyout_s = bus_a.hreadyout_s;
    assign bus_b.hresp_s     = bus_a.hresp_s;

    ahb_resp_mux_n #(.NUM_SLAVES(NS), .DATA_W(DW), .CNT_W(8)) dut_a (
        .hclk(clk), .hreset(rst), .bus(bus_a)
    );
    ahb_resp_mux_n #(.NUM_SLAVES(NS), .DATA_W(DW), .CNT_W(2)) dut_b (
        .hclk(clk), .hreset(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rdy;
        logic          resp;
        logic [DW-1:0] data;
        logic [NS-1:0] dsel;
        logic [7:0]    cnt;
        logic [1:0]    cnt2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;

    function automatic logic [DW-1:0] sd(input int i);
        return 32'hCAFE_0000 | DW'(i);
    endfunction

    task automatic bad_decode();
        exp_cnt = exp_cnt + 1;
        if (exp_cnt2 < 3) exp_cnt2 = exp_cnt2 + 1;
    endtask

    // Called at posedge+1 with inputs already driven; checks before the next edge.
    task automatic chk(input string tag, input logic rdy, input logic resp,
                       input logic [DW-1:0] data, input logic [NS-1:0] dsel);
        exp_t e;
        e.rdy  = rdy;
        e.resp = resp;
        e.data = data;
        e.dsel = dsel;
        e.cnt  = 8'(exp_cnt);
        e.cnt2 = 2'(exp_cnt2);
        sb.push_back(e);
        #4;
        e = sb.pop_front();
        n_cmp++;
        assert (bus_a.hready === e.rdy) else begin
            n_bad++; $error("FAIL %s hready obs=%b exp=%b", tag, bus_a.hready, e.rdy);
        end
        n_cmp++;
        assert (bus_a.hresp === e.resp) else begin
            n_bad++; $error("FAIL %s hresp obs=%b exp=%b", tag, bus_a.hresp, e.resp);
        end
        n_cmp++;
        assert (bus_a.hr_data === e.data) else begin
            n_bad++; $error("FAIL %s hr_data obs=%h exp=%h", tag, bus_a.hr_data, e.data);
        end
        n_cmp++;
        assert (bus_a.dsel === e.dsel) else begin
            n_bad++; $error("FAIL %s dsel obs=%b exp=%b", tag, bus_a.dsel, e.dsel);
        end
        n_cmp++;
        assert (bus_a.err_count === e.cnt) else begin
            n_bad++; $error("FAIL %s err_count obs=%0d exp=%0d", tag, bus_a.err_count, e.cnt);
        end
        n_cmp++;
        assert (bus_b.err_count === e.cnt2) else begin
            n_bad++; $error("FAIL %s err_count_w2 obs=%0d exp=%0d", tag, bus_b.err_count, e.cnt2);
        end
        n_cmp++;
        assert ({bus_b.hready, bus_b.hresp, bus_b.hr_data} === {e.rdy, e.resp, e.data}) else begin
            n_bad++; $error("FAIL %s inst_b obs=%b/%b/%h exp=%b/%b/%h", tag, bus_b.hready,
                            bus_b.hresp, bus_b.hr_data, e.rdy, e.resp, e.data);
        end
        $display("cycle %-12s hready=%b hresp=%b hr_data=%h dsel=%b cnt=%0d cnt2=%0d",
                 tag, bus_a.hready, bus_a.hresp, bus_a.hr_data, bus_a.dsel,
                 bus_a.err_count, bus_b.err_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.hrdata_s    = {sd(3), sd(2), sd(1), sd(0)};
        bus_a.hreadyout_s = '1;
        bus_a.hresp_s     = '0;
        bus_a.htrans      = IDLE;
        bus_a.hsel_in     = '0;

        // Reset with random inputs for two edges, then check while still in reset.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_a.htrans      = 2'($urandom);
            bus_a.hsel_in     = NS'($urandom);
            bus_a.hreadyout_s = NS'($urandom);
            bus_a.hresp_s     = NS'($urandom);
            @(posedge clk);
        end
        #1;
        chk("reset", 1'b1, 1'b0, '0, '0);
        rst = 1'b0;
        bus_a.htrans = IDLE; bus_a.hsel_in = '0;
        bus_a.hreadyout_s = '1; bus_a.hresp_s = '0;
        chk("post_rst", 1'b1, 1'b0, '0, '0);

        // Slave 2 with two wait states.
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0100;
        chk("s2_addr", 1'b1, 1'b0, '0, '0);
        bus_a.htrans = IDLE; bus_a.hsel_in = '0; bus_a.hreadyout_s = 4'b1011;
        chk("s2_wait1", 1'b0, 1'b0, sd(2), 4'b0100);
        chk("s2_wait2", 1'b0, 1'b0, sd(2), 4'b0100);
        bus_a.hreadyout_s = '1;
        chk("s2_done", 1'b1, 1'b0, sd(2), 4'b0100);
        chk("s2_after", 1'b1, 1'b0, '0, '0);

        // Back-to-back slave 0 then slave 3; unselected slaves are stalling.
        bus_a.hreadyout_s = 4'b1001;
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0001;
        chk("b2b_a0", 1'b1, 1'b0, '0, '0);
        bus_a.hsel_in = 4'b1000;
        chk("b2b_d0_a3", 1'b1, 1'b0, sd(0), 4'b0001);
        bus_a.htrans = IDLE; bus_a.hsel_in = '0;
        chk("b2b_d3", 1'b1, 1'b0, sd(3), 4'b1000);
        bus_a.hreadyout_s = '1;
        chk("b2b_after", 1'b1, 1'b0, '0, '0);

        // Unmapped decode; master drops to IDLE in ERR1, then issues a multi-select in ERR2.
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0000;
        chk("err0_addr", 1'b1, 1'b0, '0, '0);
        bad_decode();
        bus_a.htrans = IDLE;
        chk("err0_e1", 1'b0, 1'b1, '0, '0);
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0011;
        chk("err0_e2", 1'b1, 1'b1, '0, '0);
        bad_decode();
        bus_a.htrans = IDLE; bus_a.hsel_in = '0;
        chk("err3_e1", 1'b0, 1'b1, '0, '0);
        chk("err3_e2", 1'b1, 1'b1, '0, '0);
        chk("err_after", 1'b1, 1'b0, '0, '0);

        // Three more decode errors: narrow counter saturates at 3.
        for (int k = 0; k < 3; k++) begin
            bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b1111;
            chk("sat_addr", 1'b1, 1'b0, '0, '0);
            bad_decode();
            bus_a.htrans = IDLE; bus_a.hsel_in = '0;
            chk("sat_e1", 1'b0, 1'b1, '0, '0);
            chk("sat_e2", 1'b1, 1'b1, '0, '0);
        end

        // BUSY is ignored regardless of hsel_in.
        bus_a.htrans = BUSY; bus_a.hsel_in = 4'b0000;
        chk("busy0", 1'b1, 1'b0, '0, '0);
        bus_a.hsel_in = 4'b0100;
        chk("busy1", 1'b1, 1'b0, '0, '0);
        bus_a.htrans = IDLE; bus_a.hsel_in = '0;
        chk("busy_after", 1'b1, 1'b0, '0, '0);

        // Slave-generated two-cycle ERROR passes through and is not counted.
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0010;
        chk("serr_addr", 1'b1, 1'b0, '0, '0);
        bus_a.htrans = IDLE; bus_a.hsel_in = '0;
        bus_a.hresp_s = 4'b0010; bus_a.hreadyout_s = 4'b1101;
        chk("serr_1", 1'b0, 1'b1, sd(1), 4'b0010);
        bus_a.hreadyout_s = '1;
        chk("serr_2", 1'b1, 1'b1, sd(1), 4'b0010);
        bus_a.hresp_s = '0;
        chk("serr_after", 1'b1, 1'b0, '0, '0);

        // Reset during a slave-1 wait state.
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0010;
        chk("rstw_addr", 1'b1, 1'b0, '0, '0);
        bus_a.htrans = IDLE; bus_a.hsel_in = '0; bus_a.hreadyout_s = 4'b1101;
        rst = 1'b1;
        chk("rstw_wait", 1'b0, 1'b0, sd(1), 4'b0010);
        exp_cnt = 0; exp_cnt2 = 0;
        chk("rstw_rst", 1'b1, 1'b0, '0, '0);
        rst = 1'b0; bus_a.hreadyout_s = '1;
        chk("rstw_after", 1'b1, 1'b0, '0, '0);

        // Reset during DS_ERR1.
        bus_a.htrans = NONSEQ; bus_a.hsel_in = 4'b0000;
        chk("rste_addr", 1'b1, 1'b0, '0, '0);
        bad_decode();
        bus_a.htrans = IDLE;
        rst = 1'b1;
        chk("rste_e1", 1'b0, 1'b1, '0, '0);
        exp_cnt = 0; exp_cnt2 = 0;
        rst = 1'b0;
        chk("rste_rst", 1'b1, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
